// File: rtl/mac_result_accumulator.sv
// rtl/mac_result_accumulator.sv - dot-product accumulator behind the Booth multiplier with a 2-entry result FIFO
// Optional saturating accumulation is selected by defining MAC_ACC_SAT_EN.
module mac_result_accumulator #(
    parameter int N       = 32,
    parameter int ACC_W   = 2*N+8,
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    input  logic signed [2*N-1:0]   prod,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic [CNT_W-1:0]        out_terms,
    output logic                    out_ovf
);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [MUL_LAT-1:0] pipe_valid;
    logic [MUL_LAT-1:0] pipe_last;
    logic               first;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   term_cnt;
    logic               ovf;

    logic [ACC_W-1:0]   fifo_data  [2];
    logic [CNT_W-1:0]   fifo_terms [2];
    logic               fifo_ovf   [2];
    logic               rd_ptr;
    logic               wr_ptr;
    logic [1:0]         fifo_count;

    logic               acc_in;
    logic               tail_valid;
    logic               tail_last;
    logic               push;
    logic               pop;
    logic [7:0]         lasts_in_flight;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   sum;
    logic               wrap;
    logic [ACC_W-1:0]   acc_next;
    logic [CNT_W-1:0]   cnt_next;
    logic               ovf_next;

    assign acc_in     = in_valid && in_ready;
    assign tail_valid = pipe_valid[MUL_LAT-1];
    assign tail_last  = pipe_last[MUL_LAT-1];
    assign push       = tail_valid && tail_last;
    assign out_valid  = (fifo_count != 2'd0);
    assign pop        = out_valid && out_ready;

    assign prod_ext = {{(ACC_W-2*N){prod[2*N-1]}}, prod};
    assign sum      = acc + prod_ext;
    assign wrap     = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

    // Every issued last term owns a FIFO slot before it is allowed in.
    always_comb begin
        lasts_in_flight = 8'd0;
        for (int i = 0; i < MUL_LAT; i++) begin
            lasts_in_flight = lasts_in_flight + 8'(pipe_valid[i] & pipe_last[i]);
        end
    end

    assign in_ready = ({6'b0, fifo_count} + lasts_in_flight) < 8'd2;

    always_comb begin
        acc_next = acc;
        cnt_next = term_cnt;
        ovf_next = ovf;
        if (tail_valid) begin
            if (first) begin
                acc_next = prod_ext;
                cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
                ovf_next = 1'b0;
            end else begin
                cnt_next = (&term_cnt) ? term_cnt : term_cnt + 1'b1;
`ifdef MAC_ACC_SAT_EN
                // Once railed, the sum holds there until the burst ends.
                if (!ovf) begin
                    if (wrap) begin
                        ovf_next = 1'b1;
                        acc_next = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
                    end else begin
                        acc_next = sum;
                    end
                end
`else
                acc_next = sum;
                if (wrap) ovf_next = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe_valid    <= '0;
            pipe_last     <= '0;
            first         <= 1'b1;
            acc           <= '0;
            term_cnt      <= '0;
            ovf           <= 1'b0;
            fifo_data[0]  <= '0;
            fifo_data[1]  <= '0;
            fifo_terms[0] <= '0;
            fifo_terms[1] <= '0;
            fifo_ovf[0]   <= 1'b0;
            fifo_ovf[1]   <= 1'b0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            fifo_count    <= 2'd0;
        end else begin
            pipe_valid <= {pipe_valid[MUL_LAT-2:0], acc_in};
            pipe_last  <= {pipe_last[MUL_LAT-2:0], acc_in && in_last};
            acc        <= acc_next;
            term_cnt   <= cnt_next;
            ovf        <= ovf_next;
            if (tail_valid) first <= tail_last;
            if (push) begin
                fifo_data[wr_ptr]  <= acc_next;
                fifo_terms[wr_ptr] <= cnt_next;
                fifo_ovf[wr_ptr]   <= ovf_next;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign out_data  = out_valid ? fifo_data[rd_ptr]  : '0;
    assign out_terms = out_valid ? fifo_terms[rd_ptr] : '0;
    assign out_ovf   = out_valid ? fifo_ovf[rd_ptr]   : 1'b0;

endmodule

// File: tb/tb_mac_result_accumulator.sv
// tb/tb_mac_result_accumulator.sv - scoreboard bench for mac_result_accumulator
`timescale 1ns/1ps
module tb_mac_result_accumulator;

    localparam int N       = 32;
    localparam int ACC_W   = 2*N+1;
    localparam int MUL_LAT = 3;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic signed [127:0] MAXV = (128'sd1 <<< (ACC_W-1)) - 128'sd1;
    localparam logic signed [127:0] MINV = -(128'sd1 <<< (ACC_W-1));

    typedef struct packed {
        logic [ACC_W-1:0] data;
        logic [CNT_W-1:0] terms;
        logic             ovf;
    } res_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_last = 1'b0;
    logic                  in_ready;
    logic signed [2*N-1:0] prod;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [ACC_W-1:0]      out_data;
    logic [CNT_W-1:0]      out_terms;
    logic                  out_ovf;

    logic signed [2*N-1:0] opnd = '0;
    logic signed [2*N-1:0] mpipe [MUL_LAT];

    int errors = 0;
    int checks = 0;
    res_t exp_q[$];

    logic signed [127:0] m_acc = '0;
    int                  m_cnt = 0;
    bit                  m_ovf = 1'b0;
    bit                  m_first = 1'b1;

    mac_result_accumulator #(.N(N), .ACC_W(ACC_W), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .prod(prod), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_terms(out_terms), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    // Stand-in for the multiplier: the accepted operand emerges as the product MUL_LAT edges later.
    always @(posedge clk) begin
        mpipe[0] <= (in_valid && in_ready) ? opnd : '0;
        for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign prod = mpipe[MUL_LAT-1];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_term(input logic signed [2*N-1:0] p, input bit last);
        logic signed [127:0] pe;
        logic signed [127:0] s;
        logic [ACC_W-1:0]    lo;
        pe = p;
        if (m_first) begin
            m_acc = pe;
            m_cnt = 1;
            m_ovf = 1'b0;
        end else begin
            s = m_acc + pe;
            m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
`ifdef MAC_ACC_SAT_EN
            if (!m_ovf) begin
                if (s > MAXV) begin m_ovf = 1'b1; m_acc = MAXV; end
                else if (s < MINV) begin m_ovf = 1'b1; m_acc = MINV; end
                else m_acc = s;
            end
`else
            if (s > MAXV || s < MINV) m_ovf = 1'b1;
            lo = s[ACC_W-1:0];
            m_acc = $signed(lo);
`endif
        end
        m_first = last;
        if (last) exp_q.push_back('{data: m_acc[ACC_W-1:0], terms: m_cnt[CNT_W-1:0], ovf: m_ovf});
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic send(input logic signed [2*N-1:0] p, input bit last);
        int guard = 0;
        model_term(p, last);
        in_valid = 1'b1;
        in_last  = last;
        opnd     = p;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("send_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 1000) begin
            @(negedge clk);
            g++;
        end
        check("drain_left", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        check("idle_valid", out_valid, 0);
    endtask

    always @(negedge clk) begin
        #1;
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", out_data, 0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("out_data", out_data, e.data);
                check("out_terms", out_terms, e.terms);
                check("out_ovf", out_ovf, e.ovf);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_terms", out_terms, 0);
        check("rst_out_ovf", out_ovf, 0);
        rst = 1'b1;
        @(negedge clk);

        // Four-term burst with visibility latency
        out_ready = 1'b1;
        send(5, 0);
        send(-3, 0);
        send(10, 0);
        send(7, 1);
        for (int k = 1; k <= MUL_LAT; k++) begin
            @(negedge clk);
            check("lat_out_valid", out_valid, (k == MUL_LAT) ? 1 : 0);
        end
        drain();

        // Three single-term bursts against a stalled consumer
        out_ready = 1'b0;
        send(1, 1);
        check("rdy_after1", in_ready, 1);
        send(2, 1);
        check("rdy_after2", in_ready, 0);
        repeat (5) @(negedge clk);
        check("full_valid", out_valid, 1);
        check("full_head", out_data, 1);
        check("full_rdy", in_ready, 0);
        fork
            send(3, 1);
            begin
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Push and pop on the same edge at count 1
        out_ready = 1'b0;
        send(4, 1);
        repeat (MUL_LAT + 1) @(negedge clk);
        check("pp_first_valid", out_valid, 1);
        send(5, 1);
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        check("pp_count1_valid", out_valid, 1);
        check("pp_count1_head", out_data, 5);
        @(negedge clk);
        check("pp_empty", out_valid, 0);
        drain();

        // Accumulator overflow with ACC_W = 2N+1
        send(64'sh7FFF_FFFF_FFFF_FFFF, 0);
        send(64'sh7FFF_FFFF_FFFF_FFFF, 0);
        send(64'sh7FFF_FFFF_FFFF_FFFF, 1);
        drain();
        send(-64'sh8000_0000_0000_0000, 0);
        send(-64'sh8000_0000_0000_0000, 0);
        send(-64'sh8000_0000_0000_0000, 1);
        drain();

        // Reset in the middle of a burst
        send(100, 0);
        send(200, 0);
        rst = 1'b0;
        m_first = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        rst = 1'b1;
        send(9, 1);
        drain();

        // Long burst saturating the term counter
        for (int i = 0; i < 300; i++) send(1, i == 299);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
